// File: rtl/idct_pkg.sv
// Shared definitions for the 1-D inverse DCT: default widths, FSM states and
// the basis-matrix element locator used on the packed coefficient bus.
package idct_pkg;

  localparam int IDCT_DATA_WIDTH = 16;
  localparam int IDCT_SHIFT      = 8;
  localparam int IDCT_ACC_WIDTH  = 2 * IDCT_DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } idct_state_t;

  // Element C[k][n] is stored most-significant first, row-major over k.
  function automatic int coef_lsb(input int k, input int n, input int w);
    return w * (63 - (8 * k + n));
  endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One output column of the inverse DCT: accumulates C[k][n]*y[k] over k and
// presents the rounded, saturated value of the accumulator after this cycle's add.
module idct_mac_lane
  import idct_pkg::*;
#(
  parameter int DATA_WIDTH = IDCT_DATA_WIDTH,
  parameter int SHIFT      = IDCT_SHIFT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] coef,
  input  logic signed [DATA_WIDTH-1:0] samp,
  output logic signed [DATA_WIDTH-1:0] res
);

  localparam int ACC_W = 2 * DATA_WIDTH + 3;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) << (DATA_WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(1) << (DATA_WIDTH - 1));

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0]        acc_p1;
  logic signed [ACC_W-1:0]        acc_nxt;

  function automatic logic signed [ACC_W-1:0] round_fn(input logic signed [ACC_W-1:0] a);
    return (a + HALF) >>> SHIFT;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
    if (a > MAX_V)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (a < MIN_V) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                return a[DATA_WIDTH-1:0];
  endfunction

  assign prod     = coef * samp;
  assign prod_ext = $signed({{3{prod[2*DATA_WIDTH-1]}}, prod});
  assign acc_nxt  = acc_p1 + prod_ext;

  // Stage p1: running sum over k
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  acc_p1 <= '0;
    else if (clr)  acc_p1 <= '0;
    else if (en)   acc_p1 <= acc_nxt;
  end

  // Result reflects the sum including the current term, so the last add and
  // the output register can share one edge.
  assign res = sat_fn(round_fn(acc_nxt));

endmodule

// File: rtl/idct_1d_mac.sv
// 8-point 1-D inverse DCT by sequential multiply-accumulate: eight lanes run in
// parallel over k, one term per cycle, using the transpose of the forward basis.
module idct_1d_mac
  import idct_pkg::*;
#(
  parameter int DATA_WIDTH = IDCT_DATA_WIDTH,
  parameter int SHIFT      = IDCT_SHIFT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] y0,
  input  logic signed [DATA_WIDTH-1:0] y1,
  input  logic signed [DATA_WIDTH-1:0] y2,
  input  logic signed [DATA_WIDTH-1:0] y3,
  input  logic signed [DATA_WIDTH-1:0] y4,
  input  logic signed [DATA_WIDTH-1:0] y5,
  input  logic signed [DATA_WIDTH-1:0] y6,
  input  logic signed [DATA_WIDTH-1:0] y7,
  input  logic [DATA_WIDTH*64-1:0]     coeff_vector,
  output logic signed [DATA_WIDTH-1:0] x0,
  output logic signed [DATA_WIDTH-1:0] x1,
  output logic signed [DATA_WIDTH-1:0] x2,
  output logic signed [DATA_WIDTH-1:0] x3,
  output logic signed [DATA_WIDTH-1:0] x4,
  output logic signed [DATA_WIDTH-1:0] x5,
  output logic signed [DATA_WIDTH-1:0] x6,
  output logic signed [DATA_WIDTH-1:0] x7,
  output logic                         valid,
  output logic                         busy
);

  idct_state_t                 state;
  logic [2:0]                  k_p1;
  logic signed [DATA_WIDTH-1:0] y_p0 [8];
  logic [DATA_WIDTH*64-1:0]    coef_p0;
  logic signed [DATA_WIDTH-1:0] lane_coef [8];
  logic signed [DATA_WIDTH-1:0] lane_res [8];
  logic signed [DATA_WIDTH-1:0] samp_sel;
  logic signed [DATA_WIDTH-1:0] x_p2 [8];
  logic                        vld_p2;
  logic                        busy_p2;
  logic                        ld;
  logic                        acc_en;

  assign ld     = (state == LOAD);
  assign acc_en = (state == ACCUM);

  // Stage p0: operand snapshot so input changes mid-transform are invisible
  always_ff @(posedge clk) begin
    if (ld) begin
      y_p0[0] <= y0;
      y_p0[1] <= y1;
      y_p0[2] <= y2;
      y_p0[3] <= y3;
      y_p0[4] <= y4;
      y_p0[5] <= y5;
      y_p0[6] <= y6;
      y_p0[7] <= y7;
      coef_p0 <= coeff_vector;
    end
  end

  // Lane n walks down column n of the basis matrix as k advances.
  always_comb begin
    samp_sel = y_p0[k_p1];
    for (int n = 0; n < 8; n++) begin
      lane_coef[n] = $signed(coef_p0[coef_lsb(int'(k_p1), n, DATA_WIDTH) +: DATA_WIDTH]);
    end
  end

  // Stage p1: per-column accumulation
  for (genvar n = 0; n < 8; n++) begin : g_lane
    idct_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .SHIFT     (SHIFT)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (ld),
      .en     (acc_en),
      .coef   (lane_coef[n]),
      .samp   (samp_sel),
      .res    (lane_res[n])
    );
  end

  // Stage p2: control FSM and registered results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      k_p1    <= '0;
      vld_p2  <= 1'b0;
      busy_p2 <= 1'b0;
      for (int n = 0; n < 8; n++) x_p2[n] <= '0;
    end else begin
      vld_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            busy_p2 <= 1'b1;
          end
        end
        LOAD: begin
          state   <= ACCUM;
          k_p1    <= '0;
          busy_p2 <= 1'b1;
        end
        ACCUM: begin
          k_p1 <= k_p1 + 3'd1;
          if (k_p1 == 3'd7) begin
            state   <= DONE;
            busy_p2 <= 1'b0;
            vld_p2  <= 1'b1;
            for (int n = 0; n < 8; n++) x_p2[n] <= lane_res[n];
          end
        end
        DONE: begin
          if (start) begin
            state   <= LOAD;
            busy_p2 <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x0    = x_p2[0];
  assign x1    = x_p2[1];
  assign x2    = x_p2[2];
  assign x3    = x_p2[3];
  assign x4    = x_p2[4];
  assign x5    = x_p2[5];
  assign x6    = x_p2[6];
  assign x7    = x_p2[7];
  assign valid = vld_p2;
  assign busy  = busy_p2;

endmodule

// File: tb/tb_idct_1d_mac.sv
// Directed bench for idct_1d_mac: impulse, rounding, saturation, transpose
// ordering, ignored start, back-to-back throughput and mid-transform reset.
module tb_idct_1d_mac;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] y [8];
  logic [W*64-1:0]     cv;
  logic signed [W-1:0] x [8];
  logic                valid;
  logic                busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idct_1d_mac #(.DATA_WIDTH(W), .SHIFT(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
    .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
    .coeff_vector(cv),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .valid(valid), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input int k, input int n, input int v);
    cv[W*(63-(8*k+n)) +: W] = W'(v);
  endtask

  task automatic clear_in();
    cv = '0;
    for (int i = 0; i < 8; i++) y[i] = '0;
  endtask

  // Pulse start for one sampling edge, then count cycles until valid.
  task automatic launch_wait(output int lat, output int bcnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!valid && lat < 30) begin
      bcnt += int'(busy);
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    clear_in();
    tick();
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (x[n] !== 16'sd0) begin errors++; $display("FAIL reset_x%0d: got %0d expected 0", n, x[n]); end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    int lat, bcnt;
    clear_in();
    for (int n = 0; n < 8; n++) set_c(0, n, 256);
    y[0] = 16'sd100;
    launch_wait(lat, bcnt);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL impulse_latency: got %0d expected 9", lat); end
    checks++;
    if (bcnt !== 9) begin errors++; $display("FAIL impulse_busy_cycles: got %0d expected 9", bcnt); end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (x[n] !== 16'sd100) begin errors++; $display("FAIL impulse_x%0d: got %0d expected 100", n, x[n]); end
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL impulse_valid_pulse: got %b expected 0", valid); end
    y[0] = 16'sd5;
    tick();
    tick();
    checks++;
    if (x[3] !== 16'sd100) begin errors++; $display("FAIL impulse_hold: got %0d expected 100", x[3]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL impulse_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rounding();
    int lat, bcnt;
    int yin [3] = '{1, -1, -3};
    int exp [3] = '{1, 0, -1};
    for (int t = 0; t < 3; t++) begin
      clear_in();
      for (int n = 0; n < 8; n++) set_c(0, n, 128);
      y[0] = W'(yin[t]);
      launch_wait(lat, bcnt);
      for (int n = 0; n < 8; n += 3) begin
        checks++;
        if (int'(x[n]) !== exp[t]) begin
          errors++;
          $display("FAIL round_y%0d_x%0d: got %0d expected %0d", yin[t], n, x[n], exp[t]);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int lat, bcnt;
    int yin [2] = '{32767, -32768};
    for (int t = 0; t < 2; t++) begin
      clear_in();
      for (int k = 0; k < 8; k++)
        for (int n = 0; n < 8; n++) set_c(k, n, 256);
      for (int i = 0; i < 8; i++) y[i] = W'(yin[t]);
      launch_wait(lat, bcnt);
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (int'(x[n]) !== yin[t]) begin
          errors++;
          $display("FAIL sat_x%0d: got %0d expected %0d", n, x[n], yin[t]);
        end
      end
      tick();
    end
  endtask

  // Row 0 = 256, row 1 = 256*(n+1); y0=10, y1=3 gives x[n] = 10 + 3*(n+1).
  // Start is re-pulsed during ACCUM and the inputs scrambled after LOAD.
  task automatic test_ignored_start();
    int lat, vcnt;
    clear_in();
    for (int n = 0; n < 8; n++) begin
      set_c(0, n, 256);
      set_c(1, n, 256 * (n + 1));
    end
    y[0] = 16'sd10;
    y[1] = 16'sd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) y[i] = 16'sd1000;
    for (int n = 0; n < 8; n++) set_c(2, n, 256);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 5;
    while (!valid && lat < 30) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL ignored_latency: got %0d expected 9", lat); end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (int'(x[n]) !== 10 + 3 * (n + 1)) begin
        errors++;
        $display("FAIL ignored_x%0d: got %0d expected %0d", n, x[n], 10 + 3 * (n + 1));
      end
    end
    vcnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      vcnt += int'(valid);
    end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL ignored_extra_valid: got %0d expected 0", vcnt); end
  endtask

  task automatic test_back_to_back();
    int vcyc [2];
    int vval [2];
    int vcnt;
    clear_in();
    for (int n = 0; n < 8; n++) set_c(0, n, 256);
    y[0] = 16'sd100;
    vcnt = 0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      if (c == 2) y[0] = -16'sd50;
      if (c == 11) start = 1'b0;
      tick();
      if (valid) begin
        if (vcnt < 2) begin
          vcyc[vcnt] = c;
          vval[vcnt] = int'(x[c % 8]);
        end
        vcnt++;
      end
    end
    start = 1'b0;
    checks++;
    if (vcnt !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 2", vcnt);
    end else begin
      checks++;
      if (vcyc[1] - vcyc[0] !== 10) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d expected 10", vcyc[1] - vcyc[0]);
      end
      checks++;
      if (vval[0] !== 100) begin errors++; $display("FAIL b2b_first: got %0d expected 100", vval[0]); end
      checks++;
      if (vval[1] !== -50) begin errors++; $display("FAIL b2b_second: got %0d expected -50", vval[1]); end
    end
  endtask

  task automatic test_reset_mid_accum();
    int lat, bcnt, vcnt;
    clear_in();
    for (int n = 0; n < 8; n++) set_c(0, n, 256);
    y[0] = 16'sd90;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (x[0] !== 16'sd0 || x[7] !== 16'sd0) begin
      errors++;
      $display("FAIL midreset_x: got %0d/%0d expected 0/0", x[0], x[7]);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    tick();
    reset_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      vcnt += int'(valid);
    end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL midreset_valid: got %0d expected 0", vcnt); end
    y[0] = 16'sd77;
    launch_wait(lat, bcnt);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL midreset_restart_latency: got %0d expected 9", lat); end
    for (int n = 0; n < 8; n += 7) begin
      checks++;
      if (x[n] !== 16'sd77) begin errors++; $display("FAIL midreset_restart_x%0d: got %0d expected 77", n, x[n]); end
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_ignored_start();
    test_back_to_back();
    tick();
    tick();
    test_reset_mid_accum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idct_1d_mac.md
IDCT_1D_MAC -- requirements
Module: idct_1d_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the sample and coefficient width in bits; all values are signed two's complement.
REQ-002 Parameter SHIFT, default 8, sets the number of fractional bits in each coefficient.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to transform; sampled only in IDLE or DONE.
REQ-006 Ports y0..y7, input, DATA_WIDTH each: DCT coefficient vector to be inverted.
REQ-007 Port coeff_vector, input, DATA_WIDTH*64 bits: basis matrix C[k][n] (same layout as dct_1d_fusion), at bits [DATA_WIDTH*(63-(8k+n)) +: DATA_WIDTH], where k is the row/frequency.
REQ-008 Ports x0..x7, output, DATA_WIDTH each: reconstructed samples.
REQ-009 Port valid, output, 1 bit: one-cycle pulse; x0..x7 are new and stable.
REQ-010 Port busy, output, 1 bit: high while a transform is in flight (LOAD/ACCUM).

Function
REQ-011 Compute x[n] = sat(round(sum over k=0..7 of C[k][n]*y[k], SHIFT)) for n=0..7, the transpose of the forward matrix product.
REQ-012 Hold one accumulator per n, ACC_WIDTH = 2*DATA_WIDTH+3 bits, signed, with no intermediate overflow.
REQ-013 Rounding: add 2^(SHIFT-1), then shift right arithmetically by SHIFT (round half up).
REQ-014 Saturation: clamp the rounded result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-015 FSM states and transitions:
- IDLE -> LOAD on start=1;
- LOAD -> ACCUM after 1 cycle;
- ACCUM -> DONE after 8 cycles;
- DONE -> LOAD if start=1, else DONE -> IDLE.
REQ-016 LOAD: latch y0..y7 and coeff_vector into internal registers; clear the accumulators and the k counter.
REQ-017 Input changes after LOAD do not affect the transform in progress.
REQ-018 ACCUM: on each cycle, add C[k][n]*y[k] to accumulator n for all n in parallel, then increment k (3-bit, 0..7).
REQ-019 Leave ACCUM when k=7 has been accumulated.
REQ-020 DONE: register the rounded and saturated x0..x7 and assert valid for exactly one cycle.
REQ-021 Latency: start sampled high at edge E gives valid high in the cycle after edge E+9.
REQ-022 Throughput: one transform per 10 cycles when start is held high (back-to-back via DONE -> LOAD).
REQ-023 start in LOAD/ACCUM is ignored; it is not queued.
REQ-024 x0..x7 hold their last values until the next DONE.
REQ-025 busy = 1 in LOAD and ACCUM, 0 in IDLE and DONE.

Reset
REQ-026 reset_n low, asynchronously: state IDLE, k=0, accumulators 0, x0..x7=0, valid=0, busy=0.
REQ-027 Reset during LOAD/ACCUM/DONE aborts the transform; no valid pulse is produced for it.
REQ-028 After release, the first start is accepted on the first rising edge with reset_n high.

Structure
REQ-029 Shared package idct_pkg: DATA_WIDTH and SHIFT defaults, ACC_WIDTH, the state enum (IDLE, LOAD, ACCUM, DONE), and the coefficient-index helper.
REQ-030 Sub-module idct_mac_lane, instantiated 8 times (one per n), holds the multiply-accumulate, rounding and saturation for one output.
REQ-031 The top level holds the FSM, k counter, input latches and output registers.

Verification
REQ-032 Impulse: C[0][n]=256 for all n, other C=0, y=(100,0,...,0), start at edge 0 -> valid after edge 9, x0..x7 all 100, busy high for 9 cycles.
REQ-033 Saturation: all C=256, all y=32767 -> all x=32767; all y=-32768 -> all x=-32768.
REQ-034 Rounding: C[0][n]=128, others 0; y0=1 -> all x=1; y0=-1 -> all x=0; y0=-3 -> all x=-1.
REQ-035 Ignored start: pulse start again at edges 3 and 5 during ACCUM, with inputs changed after LOAD -> one valid only, result from the original inputs.
REQ-036 Back-to-back: hold start high with two different vectors -> valid pulses exactly 10 cycles apart, each output correct.
REQ-037 Reset mid-ACCUM: assert reset_n low at edge 4 -> outputs 0 immediately, no valid pulse; a fresh start then completes normally.
